oven_display_seq: RTL and testbench

- Next-generation oven front-panel display driver; sits between the oven control FSM and the six 7-segment digits (hex5..hex0).
- Power off: shows the cook timer as MM-SS. Power on: shows current temperature (hex5..hex3) and target temperature (hex2..hex0).
- Replaces combinational divide/modulo with a sequential divide-by-60 and a shared serial binary-to-BCD converter.
- Adds saturation, leading-zero blanking, a start/busy/done handshake and a blinking target while heating.

---
 rtl/oven_display_seq_pkg.sv | 61 ++++++
 rtl/oven_display_seq_if.sv | 30 +++
 rtl/oven_display_seq_bin2bcd.sv | 61 ++++++
 rtl/oven_display_seq.sv | 177 +++++++++++++++++
 tb/tb_oven_display_seq.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/oven_display_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : oven_display_pkg
// Desc   : Segment codes, conversion limits and FSM encoding for the display.
// Rev    : 1.0
// ============================================================================
package oven_display_pkg;

    localparam int CONV_W     = 10;
    localparam int BCD_DIGITS = 3;
    localparam int MAX_MIN    = 99;
    localparam int MAX_TEMP   = 999;

    // Active-low segments, bit order a..g (a is the leftmost bit).
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b0100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0000100;
    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_DIV60  = 3'd1;
    localparam state_t S_CONV_A = 3'd2;
    localparam state_t S_CONV_B = 3'd3;
    localparam state_t S_COMMIT = 3'd4;

    function automatic logic [0:6] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Three-digit field with leading-zero blanking; the ones digit always shows.
    function automatic logic [20:0] field3(input logic [11:0] b);
        logic [0:6] h;
        logic [0:6] t;
        h = (b[11:8] == 4'd0) ? SEG_BLANK : seg_digit(b[11:8]);
        t = (b[11:4] == 8'd0) ? SEG_BLANK : seg_digit(b[7:4]);
        return {h, t, seg_digit(b[3:0])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/oven_display_seq_if.sv
`default_nettype none
// ============================================================================
// Module : oven_display_seq_if
// Desc   : Request/response and segment bundle between oven control and display.
// Rev    : 1.0
// ============================================================================
interface oven_display_seq_if #(
    parameter int TIME_W = 13,
    parameter int TEMP_W = 10
);
    logic              start;
    logic              power;
    logic [TIME_W-1:0] current_time;
    logic [TEMP_W-1:0] current_temp;
    logic [TEMP_W-1:0] target_temp;
    logic              busy;
    logic              done;
    logic [0:6]        hex0, hex1, hex2, hex3, hex4, hex5;

    modport master (
        output start, power, current_time, current_temp, target_temp,
        input  busy, done, hex0, hex1, hex2, hex3, hex4, hex5
    );

    modport slave (
        input  start, power, current_time, current_temp, target_temp,
        output busy, done, hex0, hex1, hex2, hex3, hex4, hex5
    );
endinterface
`default_nettype wire

// File: rtl/oven_display_seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module : bin2bcd_seq
// Desc   : Serial double-dabble, one bit per cycle; the load cycle is step one.
// Rev    : 1.0
// ============================================================================
module bin2bcd_seq
    import oven_display_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [CONV_W-1:0]       value,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    valid
);
    localparam int CNT_W = $clog2(CONV_W + 1);

    logic [CONV_W-1:0]       r_bin;
    logic [4*BCD_DIGITS-1:0] r_acc;
    logic [CNT_W-1:0]        r_left;
    logic [CONV_W-1:0]       w_bin;
    logic [4*BCD_DIGITS-1:0] w_src;
    logic [4*BCD_DIGITS-1:0] w_adj;
    logic                    w_step;

    always_comb begin
        w_bin = load ? value : r_bin;
        w_src = load ? '0 : r_acc;
        w_adj = w_src;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (w_src[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = w_src[4*i +: 4] + 4'd3;
        end
    end

    assign w_step = load || (r_left != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin  <= '0;
            r_acc  <= '0;
            r_left <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= !load && (r_left == CNT_W'(1));
            if (w_step) begin
                r_acc <= {w_adj[4*BCD_DIGITS-2:0], w_bin[CONV_W-1]};
                r_bin <= {w_bin[CONV_W-2:0], 1'b0};
            end
            if (load)
                r_left <= CNT_W'(CONV_W - 1);
            else if (r_left != '0)
                r_left <= r_left - 1'b1;
        end
    end

    assign bcd = r_acc;

endmodule
`default_nettype wire

// File: rtl/oven_display_seq.sv
`default_nettype none
// ============================================================================
// Module : oven_display_seq
// Desc   : Sequential timer/temperature front-panel driver with blinking setpoint.
// Rev    : 1.0
// ============================================================================
module oven_display_seq
    import oven_display_pkg::*;
#(
    parameter int TIME_W    = 13,
    parameter int TEMP_W    = 10,
    parameter int BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    oven_display_seq_if.slave bus
);
    localparam int MAX_STEPS = (TIME_W > CONV_W) ? TIME_W : CONV_W;
    localparam int CNT_W     = $clog2(MAX_STEPS + 1);
    localparam int BLK_W     = $clog2(BLINK_DIV);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pwr;
    logic [TIME_W-1:0] r_div;
    logic [5:0]        r_rem;
    logic [TEMP_W-1:0] r_cur;
    logic [TEMP_W-1:0] r_tgt;
    logic [11:0]       r_bcd_a;
    logic              r_heat, r_busy, r_done;
    logic [0:6]        r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
    logic [BLK_W-1:0]  r_blk;
    logic              r_phase, r_mask;

    logic [6:0]        w_trial, w_sub;
    logic              w_ge, w_min_sat, w_heat_next, w_conv_load, w_conv_valid;
    logic [CONV_W-1:0] w_conv_value;
    logic [11:0]       w_conv_bcd;

    function automatic logic [CONV_W-1:0] clamp_temp(input logic [TEMP_W-1:0] t);
        if (int'(t) > MAX_TEMP)
            return CONV_W'(MAX_TEMP);
        return CONV_W'(t);
    endfunction

    // Restoring divide-by-60: remainder stays below 60, so 6 bits plus the incoming bit.
    assign w_trial   = {r_rem, r_div[TIME_W-1]};
    assign w_sub     = w_trial - 7'd60;
    assign w_ge      = (w_trial >= 7'd60);
    assign w_min_sat = (r_div > TIME_W'(MAX_MIN));

    always_comb begin
        w_conv_value = '0;
        if (r_pwr)
            w_conv_value = (r_state == S_CONV_A) ? clamp_temp(r_cur) : clamp_temp(r_tgt);
        else if (w_min_sat)
            w_conv_value = (r_state == S_CONV_A) ? CONV_W'(MAX_MIN) : CONV_W'(59);
        else
            w_conv_value = (r_state == S_CONV_A) ? CONV_W'(r_div) : CONV_W'(r_rem);
    end

    assign w_conv_load = ((r_state == S_CONV_A) || (r_state == S_CONV_B)) && (r_cnt == '0);
    assign w_heat_next = (r_state == S_COMMIT) ? (r_pwr && (r_cur < r_tgt)) : r_heat;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .load  (w_conv_load),
        .value (w_conv_value),
        .bcd   (w_conv_bcd),
        .valid (w_conv_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pwr   <= 1'b0;
            r_div   <= '0;
            r_rem   <= '0;
            r_cur   <= '0;
            r_tgt   <= '0;
            r_bcd_a <= '0;
            r_heat  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hex0  <= SEG_BLANK;
            r_hex1  <= SEG_BLANK;
            r_hex2  <= SEG_BLANK;
            r_hex3  <= SEG_BLANK;
            r_hex4  <= SEG_BLANK;
            r_hex5  <= SEG_BLANK;
        end else begin
            r_done <= 1'b0;
            r_heat <= w_heat_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pwr   <= bus.power;
                        r_div   <= bus.current_time;
                        r_cur   <= bus.current_temp;
                        r_tgt   <= bus.target_temp;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= bus.power ? S_CONV_A : S_DIV60;
                    end
                end
                S_DIV60: begin
                    r_rem <= w_ge ? w_sub[5:0] : w_trial[5:0];
                    r_div <= {r_div[TIME_W-2:0], w_ge};
                    if (r_cnt == CNT_W'(TIME_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_CONV_A;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CONV_A, S_CONV_B: begin
                    // Converter presents field A's result in the first CONV_B cycle.
                    if (r_state == S_CONV_B && w_conv_valid)
                        r_bcd_a <= w_conv_bcd;
                    if (r_cnt == CNT_W'(CONV_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= (r_state == S_CONV_A) ? S_CONV_B : S_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (r_pwr) begin
                        {r_hex5, r_hex4, r_hex3} <= field3(r_bcd_a);
                        {r_hex2, r_hex1, r_hex0} <= field3(w_conv_bcd);
                    end else begin
                        r_hex5 <= SEG_BLANK;
                        r_hex4 <= (r_bcd_a[7:4] == 4'd0) ? SEG_BLANK : seg_digit(r_bcd_a[7:4]);
                        r_hex3 <= seg_digit(r_bcd_a[3:0]);
                        r_hex2 <= SEG_DASH;
                        r_hex1 <= seg_digit(w_conv_bcd[7:4]);
                        r_hex0 <= seg_digit(w_conv_bcd[3:0]);
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk   <= '0;
            r_phase <= 1'b1;
            r_mask  <= 1'b0;
        end else begin
            r_mask <= w_heat_next && !r_phase;
            if (r_blk == BLK_W'(BLINK_DIV - 1)) begin
                r_blk   <= '0;
                r_phase <= !r_phase;
            end else begin
                r_blk <= r_blk + 1'b1;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hex5 = r_hex5;
    assign bus.hex4 = r_hex4;
    assign bus.hex3 = r_hex3;
    assign bus.hex2 = r_mask ? SEG_BLANK : r_hex2;
    assign bus.hex1 = r_mask ? SEG_BLANK : r_hex1;
    assign bus.hex0 = r_mask ? SEG_BLANK : r_hex0;

endmodule
`default_nettype wire

// File: tb/tb_oven_display_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_oven_display_seq
// Desc   : Directed vector bench for the oven display driver.
// Rev    : 1.0
// ============================================================================
module tb_oven_display_seq;
    localparam int TIME_W    = 13;
    localparam int TEMP_W    = 11;
    localparam int BLINK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    oven_display_seq_if #(.TIME_W(TIME_W), .TEMP_W(TEMP_W)) bus ();

    oven_display_seq #(
        .TIME_W    (TIME_W),
        .TEMP_W    (TEMP_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        bit        pwr;
        int        tim;
        int        cur;
        int        tgt;
        int        lat;
        bit        heat;
        bit [47:0] disp;
    } vec_t;

    vec_t vecs [12];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [41:0] disp;
    assign disp = {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};

    // Blink reference: m_prev is the phase before the most recent edge.
    int m_cnt;
    bit m_phase, m_prev;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_phase <= 1'b1;
            m_prev  <= 1'b1;
        end else begin
            m_prev <= m_phase;
            if (m_cnt == BLINK_DIV - 1) begin
                m_cnt   <= 0;
                m_phase <= !m_phase;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    function automatic logic [6:0] seg_c(input bit [7:0] c);
        case (c)
            "0":     return 7'b0000001;
            "1":     return 7'b1001111;
            "2":     return 7'b0010010;
            "3":     return 7'b0000110;
            "4":     return 7'b1001100;
            "5":     return 7'b0100100;
            "6":     return 7'b0100000;
            "7":     return 7'b0001111;
            "8":     return 7'b0000000;
            "9":     return 7'b0000100;
            "-":     return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] expect_disp(input bit [47:0] s, input bit blank_lo);
        logic [41:0] r;
        for (int i = 0; i < 6; i++)
            r[7*(5-i) +: 7] = seg_c(s[8*(5-i) +: 8]);
        if (blank_lo)
            r[20:0] = {3{7'b1111111}};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int busy_bad;
        @(negedge clk);
        bus.power        = v.pwr;
        bus.current_time = TIME_W'(v.tim);
        bus.current_temp = TEMP_W'(v.cur);
        bus.target_temp  = TEMP_W'(v.tgt);
        bus.start        = 1'b1;
        @(negedge clk);
        // Scramble inputs after acceptance; the conversion must use latched values.
        bus.start        = 1'b0;
        bus.power        = !v.pwr;
        bus.current_time = ~bus.current_time;
        bus.current_temp = ~bus.current_temp;
        bus.target_temp  = ~bus.target_temp;
        lat      = 0;
        busy_bad = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy !== 1'b0) busy_bad++;
        chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, "_display"}, 64'(disp), 64'(expect_disp(v.disp, v.pwr && v.heat && !m_prev)));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [41:0] e;
        logic [20:0] hi0, exp_lo;
        int          hi_bad, lo_bad, n_blank, n_dig, dones, dl;
        logic [41:0] seen;

        vecs[0]  = '{1'b0,  754,    0,    0, 34, 1'b0, " 12-34"};
        vecs[1]  = '{1'b0,   65,    0,    0, 34, 1'b0, "  1-05"};
        vecs[2]  = '{1'b0, 8191,    0,    0, 34, 1'b0, " 99-59"};
        vecs[3]  = '{1'b0,    0,    0,    0, 34, 1'b0, "  0-00"};
        vecs[4]  = '{1'b0, 5999,    0,    0, 34, 1'b0, " 99-59"};
        vecs[5]  = '{1'b0,  600,    0,    0, 34, 1'b0, " 10-00"};
        vecs[6]  = '{1'b1,    0,   75,  350, 21, 1'b1, " 75350"};
        vecs[7]  = '{1'b1,    0,  350,  350, 21, 1'b0, "350350"};
        vecs[8]  = '{1'b1,    0, 1500,    0, 21, 1'b0, "999  0"};
        vecs[9]  = '{1'b1,    0,    0,    5, 21, 1'b1, "  0  5"};
        vecs[10] = '{1'b1,    0, 1000,  999, 21, 1'b0, "999999"};
        vecs[11] = '{1'b1,    0,  999, 1000, 21, 1'b1, "999999"};

        bus.start        = 1'b0;
        bus.power        = 1'b0;
        bus.current_time = '0;
        bus.current_temp = '0;
        bus.target_temp  = '0;
        repeat (3) @(negedge clk);
        chk("reset_display", 64'(disp), 64'(expect_disp("      ", 1'b0)));
        chk("reset_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Heating: hex2..hex0 follow the blink phase, hex5..hex3 hold.
        run_vec(vecs[6], "blink_setup");
        e      = expect_disp(vecs[6].disp, 1'b0);
        hi0    = e[41:21];
        hi_bad = 0; lo_bad = 0; n_blank = 0; n_dig = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_lo = !m_prev ? {3{7'b1111111}} : e[20:0];
            if (disp[41:21] !== hi0) hi_bad++;
            if (disp[20:0] !== exp_lo) lo_bad++;
            if (disp[20:0] === {3{7'b1111111}}) n_blank++; else n_dig++;
        end
        chk("blink_hi_steady", 64'(hi_bad), 64'd0);
        chk("blink_lo_phase", 64'(lo_bad), 64'd0);
        chk("blink_both_phases", 64'(n_blank > 0 && n_dig > 0), 64'd1);

        // Equal temperatures: no blinking.
        run_vec(vecs[7], "noblink_setup");
        e      = expect_disp(vecs[7].disp, 1'b0);
        hi_bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (disp !== e) hi_bad++;
        end
        chk("noblink_steady", 64'(hi_bad), 64'd0);

        // Second start while busy is ignored.
        @(negedge clk);
        bus.power = 1'b0; bus.current_time = TIME_W'(754); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.current_time = TIME_W'(65); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; dl = -1; seen = '0;
        for (int c = 5; c < 60; c++) begin
            if (bus.done === 1'b1) begin
                dones++;
                if (dl < 0) begin dl = c; seen = disp; end
            end
            @(negedge clk);
        end
        chk("ignore_done_count", 64'(dones), 64'd1);
        chk("ignore_latency", 64'(dl), 64'd34);
        chk("ignore_display", 64'(seen), 64'(expect_disp(" 12-34", 1'b0)));

        // Reset during CONV_A aborts and blanks immediately.
        @(negedge clk);
        bus.power = 1'b1; bus.current_temp = TEMP_W'(75); bus.target_temp = TEMP_W'(350);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_display", 64'(disp), 64'(expect_disp("      ", 1'b0)));
        chk("abort_busy_done", 64'({bus.busy, bus.done}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        chk("abort_idle_after", 64'(dones), 64'd0);
        chk("abort_still_blank", 64'(disp), 64'(expect_disp("      ", 1'b0)));
        v = '{1'b1, 0, 12, 3, 21, 1'b0, " 12  3"};
        run_vec(v, "after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
